// File: rtl/csa_selftest_checker.sv
// Exhaustive self-test driver/checker for a combinational WIDTH-bit adder.
// Sweeps every {cin, a, b} vector, compares against a golden sum, and records the first failure.
module csa_selftest_checker #(
    parameter int WIDTH         = 6,
    parameter int MAX_VEC       = 2**(2*WIDTH+1),
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   dut_a,
    output logic [WIDTH-1:0]   dut_b,
    output logic               dut_cin,
    input  logic [WIDTH-1:0]   dut_sum,
    input  logic               dut_cout,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic [2*WIDTH:0]   vec_idx,
    output logic               fail_valid,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b,
    output logic               fail_cin,
    output logic [1:0]         state_dbg
);

    localparam int VW = 2*WIDTH + 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [VW-1:0] LAST_IDX    = VW'(MAX_VEC - 1);
    localparam logic [SW-1:0] LAST_SETTLE = SW'(SETTLE_CYCLES - 1);

    // Handshake: start is a one-cycle request honoured only in IDLE or DONE;
    // busy is high from the cycle after an accepted start until done rises.
    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

    state_t             state, state_nx;
    logic [SW-1:0]      settle, settle_nx;
    logic [VW-1:0]      vec_nx;
    logic [ERR_W-1:0]   err_nx;
    logic               fv_nx, fcin_nx;
    logic [WIDTH-1:0]   fa_nx, fb_nx;
    logic [WIDTH:0]     expected;
    logic               mismatch;

    // Operands come straight from the vector register, so they are glitch-free flops.
    assign {dut_cin, dut_a, dut_b} = vec_idx;

    assign expected  = {1'b0, dut_a} + {1'b0, dut_b} + {{WIDTH{1'b0}}, dut_cin};
    assign mismatch  = {dut_cout, dut_sum} != expected;
    assign busy      = (state == APPLY) || (state == CHECK);
    assign done      = (state == DONE);
    assign pass      = done && (err_count == '0);
    assign state_dbg = state;

    always_comb begin
        state_nx  = state;
        settle_nx = settle;
        vec_nx    = vec_idx;
        err_nx    = err_count;
        fv_nx     = fail_valid;
        fa_nx     = fail_a;
        fb_nx     = fail_b;
        fcin_nx   = fail_cin;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx  = APPLY;
                    settle_nx = '0;
                    vec_nx    = '0;
                    err_nx    = '0;
                    fv_nx     = 1'b0;
                    fa_nx     = '0;
                    fb_nx     = '0;
                    fcin_nx   = 1'b0;
                end
            end
            APPLY: begin
                if (settle == LAST_SETTLE) begin
                    state_nx  = CHECK;
                    settle_nx = '0;
                end else begin
                    settle_nx = settle + SW'(1);
                end
            end
            CHECK: begin
                if (mismatch) begin
                    if (err_count != '1) err_nx = err_count + ERR_W'(1);
                    if (!fail_valid) begin
                        fv_nx   = 1'b1;
                        fa_nx   = dut_a;
                        fb_nx   = dut_b;
                        fcin_nx = dut_cin;
                    end
                end
                // The final vector stays on the bus once the sweep completes.
                if (vec_idx == LAST_IDX) begin
                    state_nx = DONE;
                end else begin
                    vec_nx   = vec_idx + VW'(1);
                    state_nx = APPLY;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            settle     <= '0;
            vec_idx    <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_cin   <= 1'b0;
        end else begin
            state      <= state_nx;
            settle     <= settle_nx;
            vec_idx    <= vec_nx;
            err_count  <= err_nx;
            fail_valid <= fv_nx;
            fail_a     <= fa_nx;
            fail_b     <= fb_nx;
            fail_cin   <= fcin_nx;
        end
    end

endmodule

// File: tb/tb_csa_selftest_checker.sv
// Bench for csa_selftest_checker: three instances (default, short/slow, narrow error counter)
// driving behavioural adders with selectable stuck-at faults; results checked from a scoreboard.
module tb_csa_selftest_checker;

    typedef struct packed {
        logic [15:0] cycles;
        logic [15:0] err;
        logic        pass;
        logic        fail_valid;
        logic [5:0]  fail_a;
        logic [5:0]  fail_b;
        logic        fail_cin;
        logic [12:0] vec;
        logic [5:0]  a;
        logic [5:0]  b;
        logic        cin;
        logic        busy;
    } result_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   fault0 = 0;
    int   start_cyc[3];
    logic [2:0] done_q = '0;

    result_t exp_q0[$];
    result_t exp_q1[$];
    result_t exp_q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT 0: defaults, fault-selectable adder
    logic start0 = 1'b0;
    logic [5:0] dut_a0, dut_b0, dut_sum0, fail_a0, fail_b0;
    logic dut_cin0, dut_cout0, busy0, done0, pass0, fail_valid0, fail_cin0;
    logic [15:0] err_count0;
    logic [12:0] vec_idx0;
    logic [1:0] state0;
    logic [6:0] add0;

    always_comb begin
        add0 = {1'b0, dut_a0} + {1'b0, dut_b0} + {6'b0, dut_cin0};
        if (fault0 == 1) add0[0] = 1'b0;
        if (fault0 == 2) add0[6] = 1'b0;
    end
    assign {dut_cout0, dut_sum0} = add0;

    csa_selftest_checker u0 (
        .clk(clk), .rst(rst), .start(start0),
        .dut_a(dut_a0), .dut_b(dut_b0), .dut_cin(dut_cin0),
        .dut_sum(dut_sum0), .dut_cout(dut_cout0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err_count0),
        .vec_idx(vec_idx0), .fail_valid(fail_valid0),
        .fail_a(fail_a0), .fail_b(fail_b0), .fail_cin(fail_cin0),
        .state_dbg(state0)
    );

    // ---------------- DUT 1: 16 vectors, 3 settle cycles, correct adder
    logic start1 = 1'b0;
    logic [5:0] dut_a1, dut_b1, dut_sum1, fail_a1, fail_b1;
    logic dut_cin1, dut_cout1, busy1, done1, pass1, fail_valid1, fail_cin1;
    logic [15:0] err_count1;
    logic [12:0] vec_idx1;
    logic [1:0] state1;

    assign {dut_cout1, dut_sum1} = {1'b0, dut_a1} + {1'b0, dut_b1} + {6'b0, dut_cin1};

    csa_selftest_checker #(.MAX_VEC(16), .SETTLE_CYCLES(3)) u1 (
        .clk(clk), .rst(rst), .start(start1),
        .dut_a(dut_a1), .dut_b(dut_b1), .dut_cin(dut_cin1),
        .dut_sum(dut_sum1), .dut_cout(dut_cout1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1),
        .vec_idx(vec_idx1), .fail_valid(fail_valid1),
        .fail_a(fail_a1), .fail_b(fail_b1), .fail_cin(fail_cin1),
        .state_dbg(state1)
    );

    // ---------------- DUT 2: 4-bit error counter, 2048 vectors, carry-out stuck at 0
    logic start2 = 1'b0;
    logic [5:0] dut_a2, dut_b2, dut_sum2, fail_a2, fail_b2;
    logic dut_cin2, dut_cout2, busy2, done2, pass2, fail_valid2, fail_cin2;
    logic [3:0] err_count2;
    logic [12:0] vec_idx2;
    logic [1:0] state2;
    logic [6:0] add2;

    assign add2 = {1'b0, dut_a2} + {1'b0, dut_b2} + {6'b0, dut_cin2};
    assign dut_sum2  = add2[5:0];
    assign dut_cout2 = 1'b0;

    csa_selftest_checker #(.MAX_VEC(2048), .ERR_W(4)) u2 (
        .clk(clk), .rst(rst), .start(start2),
        .dut_a(dut_a2), .dut_b(dut_b2), .dut_cin(dut_cin2),
        .dut_sum(dut_sum2), .dut_cout(dut_cout2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
        .vec_idx(vec_idx2), .fail_valid(fail_valid2),
        .fail_a(fail_a2), .fail_b(fail_b2), .fail_cin(fail_cin2),
        .state_dbg(state2)
    );

    // ---------------- checking helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_result(input string tag, input result_t act, input result_t exp);
        check({tag, ".cycles"},     32'(act.cycles),     32'(exp.cycles));
        check({tag, ".err_count"},  32'(act.err),        32'(exp.err));
        check({tag, ".pass"},       32'(act.pass),       32'(exp.pass));
        check({tag, ".fail_valid"}, 32'(act.fail_valid), 32'(exp.fail_valid));
        check({tag, ".fail_a"},     32'(act.fail_a),     32'(exp.fail_a));
        check({tag, ".fail_b"},     32'(act.fail_b),     32'(exp.fail_b));
        check({tag, ".fail_cin"},   32'(act.fail_cin),   32'(exp.fail_cin));
        check({tag, ".vec_idx"},    32'(act.vec),        32'(exp.vec));
        check({tag, ".dut_a"},      32'(act.a),          32'(exp.a));
        check({tag, ".dut_b"},      32'(act.b),          32'(exp.b));
        check({tag, ".dut_cin"},    32'(act.cin),        32'(exp.cin));
        check({tag, ".busy"},       32'(act.busy),       32'(exp.busy));
    endtask

    function automatic result_t mk(input int cycles, input int err, input bit p, input bit fv,
                                   input int fa, input int fb, input bit fc,
                                   input int vec, input int a, input int b, input bit cin);
        result_t r;
        r.cycles = 16'(cycles); r.err = 16'(err); r.pass = p; r.fail_valid = fv;
        r.fail_a = 6'(fa); r.fail_b = 6'(fb); r.fail_cin = fc;
        r.vec = 13'(vec); r.a = 6'(a); r.b = 6'(b); r.cin = cin; r.busy = 1'b0;
        return r;
    endfunction

    // ---------------- monitor: pops an expectation on each rising done
    always @(negedge clk) begin
        result_t act;
        done_q <= {done2, done1, done0};
        if (done0 && !done_q[0]) begin
            act = '{16'(cyc - start_cyc[0]), err_count0, pass0, fail_valid0, fail_a0, fail_b0,
                    fail_cin0, vec_idx0, dut_a0, dut_b0, dut_cin0, busy0};
            check("u0.expected_pending", 32'(exp_q0.size() != 0), 32'd1);
            if (exp_q0.size() != 0) compare_result("u0", act, exp_q0.pop_front());
        end
        if (done1 && !done_q[1]) begin
            act = '{16'(cyc - start_cyc[1]), err_count1, pass1, fail_valid1, fail_a1, fail_b1,
                    fail_cin1, vec_idx1, dut_a1, dut_b1, dut_cin1, busy1};
            check("u1.expected_pending", 32'(exp_q1.size() != 0), 32'd1);
            if (exp_q1.size() != 0) compare_result("u1", act, exp_q1.pop_front());
        end
        if (done2 && !done_q[2]) begin
            act = '{16'(cyc - start_cyc[2]), 16'(err_count2), pass2, fail_valid2, fail_a2, fail_b2,
                    fail_cin2, vec_idx2, dut_a2, dut_b2, dut_cin2, busy2};
            check("u2.expected_pending", 32'(exp_q2.size() != 0), 32'd1);
            if (exp_q2.size() != 0) compare_result("u2", act, exp_q2.pop_front());
        end
    end

    // ---------------- driver tasks
    task automatic set_start(input int id, input logic v);
        case (id)
            0: start0 = v;
            1: start1 = v;
            default: start2 = v;
        endcase
    endtask

    function automatic logic get_done(input int id);
        case (id)
            0: return done0;
            1: return done1;
            default: return done2;
        endcase
    endfunction

    // extra_at > 0 re-pulses start that many cycles into the run (must be ignored while busy).
    task automatic run(input int id, input result_t exp, input int budget, input int extra_at);
        bit seen = 1'b0;
        case (id)
            0: exp_q0.push_back(exp);
            1: exp_q1.push_back(exp);
            default: exp_q2.push_back(exp);
        endcase
        @(negedge clk);
        start_cyc[id] = cyc;
        set_start(id, 1'b1);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            set_start(id, (extra_at > 0) && (i == extra_at));
            if (get_done(id)) begin
                seen = 1'b1;
                break;
            end
        end
        set_start(id, 1'b0);
        if (!seen) check($sformatf("u%0d.done_within_budget", id), 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic check_u0_zero(input string tag);
        check({tag, ".dut_a"},      32'(dut_a0),      32'd0);
        check({tag, ".dut_b"},      32'(dut_b0),      32'd0);
        check({tag, ".dut_cin"},    32'(dut_cin0),    32'd0);
        check({tag, ".busy"},       32'(busy0),       32'd0);
        check({tag, ".done"},       32'(done0),       32'd0);
        check({tag, ".pass"},       32'(pass0),       32'd0);
        check({tag, ".err_count"},  32'(err_count0),  32'd0);
        check({tag, ".vec_idx"},    32'(vec_idx0),    32'd0);
        check({tag, ".fail_valid"}, 32'(fail_valid0), 32'd0);
        check({tag, ".fail_a"},     32'(fail_a0),     32'd0);
        check({tag, ".fail_b"},     32'(fail_b0),     32'd0);
        check({tag, ".fail_cin"},   32'(fail_cin0),   32'd0);
        check({tag, ".state"},      32'(state0),      32'd0);
    endtask

    // ---------------- main sequence
    initial begin
        bit hit;
        #1 rst = 1'b1;
        @(negedge clk);
        check_u0_zero("reset");
        check("reset.u1.busy", 32'(busy1), 32'd0);
        check("reset.u2.err_count", 32'(err_count2), 32'd0);
        rst = 1'b0;

        // Correct adder: 8192 vectors * 2 cycles + 1.
        fault0 = 0;
        run(0, mk(16385, 0, 1, 0, 0, 0, 0, 8191, 63, 63, 1), 20000, 0);

        // Abort a sum[0]-stuck run at vector 100 with an off-edge reset.
        fault0 = 1;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (vec_idx0 == 13'd100) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("abort.reached_vec100", 32'(hit), 32'd1);
        check("abort.err_before", 32'(err_count0 != 0), 32'd1);
        #3 rst = 1'b1;
        #1 check_u0_zero("abort");
        @(negedge clk);
        rst = 1'b0;

        // Fresh full run, sum[0] stuck at 0: half the vectors have an odd sum.
        run(0, mk(16385, 4096, 0, 1, 0, 1, 0, 8191, 63, 63, 1), 20000, 0);

        // Carry-out stuck at 0: first failure at a=1, b=63, cin=0.
        fault0 = 2;
        run(0, mk(16385, 4096, 0, 1, 1, 63, 0, 8191, 63, 63, 1), 20000, 0);

        // Short run with long settle; a start pulse mid-run must not restart it.
        run(1, mk(65, 0, 1, 0, 0, 0, 0, 15, 0, 15, 0), 200, 20);

        // 4-bit error counter saturates at 15 (496 real mismatches in 2048 vectors).
        run(2, mk(4097, 15, 0, 1, 1, 63, 0, 2047, 31, 63, 0), 5000, 0);

        check("end.q0_drained", 32'(exp_q0.size()), 32'd0);
        check("end.q1_drained", 32'(exp_q1.size()), 32'd0);
        check("end.q2_drained", 32'(exp_q2.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/csa_selftest_checker.md
Name: csa_selftest_checker

Overview:
- Sequential self-test harness for the WIDTH-bit carry-select adder.
- Acts as the other end of the adder's operand/result interface: it generates every operand vector, samples the adder's sum and carry-out, and compares them against a golden addition.
- Counts mismatches and captures the first failing vector, so the adder is proven exhaustively in hardware or simulation rather than by a handful of hand-picked vectors.
- Sits beside the adder instance; the adder remains purely combinational.

Parameters:
- WIDTH, 6, operand width of the adder under test.
- MAX_VEC, 2**(2*WIDTH+1), number of vectors applied per run; 1..2**(2*WIDTH+1).
- SETTLE_CYCLES, 1, cycles each vector is held before sampling; >=1.
- ERR_W, 16, width of the error counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a run.
- dut_a  output  WIDTH  operand A to the adder.
- dut_b  output  WIDTH  operand B to the adder.
- dut_cin  output  1  carry-in to the adder.
- dut_sum  input  WIDTH  adder sum.
- dut_cout  input  1  adder carry-out.
- busy  output  1  run in progress.
- done  output  1  run complete; held until the next start or reset.
- pass  output  1  done and err_count==0.
- err_count  output  ERR_W  mismatch count, saturating.
- vec_idx  output  2*WIDTH+1  index of the vector currently applied.
- fail_valid  output  1  at least one mismatch captured.
- fail_a  output  WIDTH  A of the first failing vector.
- fail_b  output  WIDTH  B of the first failing vector.
- fail_cin  output  1  cin of the first failing vector.

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs are 0: dut_a, dut_b, dut_cin, busy, done, pass, err_count, vec_idx, fail_*. The settle counter is also 0.
- Vector mapping: {dut_cin, dut_a, dut_b} = vec_idx, with dut_b in the LSBs. All dut_* outputs are registered.
- IDLE or DONE, start=1: next cycle state=APPLY, vec_idx=0, busy=1, done=0, pass=0, err_count=0, fail_*=0, settle counter=0.
- APPLY: hold the vector for SETTLE_CYCLES cycles, then go to CHECK.
- CHECK (one cycle):
  - expected = dut_a + dut_b + dut_cin, computed at WIDTH+1 bits.
  - Mismatch = {dut_cout, dut_sum} != expected.
  - On mismatch: err_count += 1, saturating at all-ones.
  - On mismatch with fail_valid==0: capture fail_a/b/cin from the current vector and set fail_valid=1.
  - If vec_idx==MAX_VEC-1: go to DONE. Otherwise increment vec_idx and go to APPLY.
- DONE: busy=0, done=1, pass=(err_count==0). The last vector stays driven, and all results hold.
- Run length: from the start cycle to done=1 is MAX_VEC*(SETTLE_CYCLES+1)+1 cycles.
- start while busy=1 is ignored; the run continues undisturbed.
- start held high in DONE starts a new run; start held high continuously restarts only from IDLE or DONE.
- rst asserted mid-run aborts immediately to reset values. No partial results are retained.
- No wrap-around: vec_idx never exceeds MAX_VEC-1.

Test Plan:
- Correct 6-bit adder, defaults, single start pulse -> done=1 exactly 8192*2+1 cycles later; err_count=0, pass=1, fail_valid=0, busy=0.
- Adder with dut_sum[0] stuck at 0 -> err_count=4096, pass=0, fail_valid=1; first failure fail_a=0, fail_b=1, fail_cin=0 (vec_idx 1).
- Adder with dut_cout stuck at 0 -> err_count=4096 (2016 with cin=0, 2080 with cin=1); first failure fail_a=1, fail_b=63, fail_cin=0 (vec_idx 127).
- MAX_VEC=16, SETTLE_CYCLES=3, correct adder -> done after 16*4+1=65 cycles; vec_idx ends at 15, showing dut_a=0, dut_b=15, dut_cin=0. A start pulse during busy changes nothing.
- Async rst pulse mid-run (vec_idx=100), not aligned to clk -> all outputs 0 immediately. A new start then runs the full 8192 vectors with a fresh err_count.
- ERR_W=4 with dut_cout stuck at 0 -> err_count saturates at 15, not wrapping; pass=0.
